iir_sos_tdm_mc: RTL and testbench

Multi-channel, time-multiplexed cascade of second-order IIR sections sharing one multiplier-accumulator. It generalises the fixed four-section multi-cycle IIR to parametrised section count, channel count and fixed-point widths. It adds runtime coefficient/scale programming, per-channel filter state, valid/ready handshakes on both sides, and saturating arithmetic with sticky overflow. It sits between the sample source and downstream DSP stages.

---
 rtl/iir_sos_tdm_mc.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_iir_sos_tdm_mc.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/iir_sos_tdm_mc.sv
// Multi-channel cascade of Direct Form I biquads time-shared on one multiplier-accumulator.
// Each sample runs SCALE/MAC0..4/WB per section, then an output scale, then a DONE handoff.
module iir_sos_tdm_mc #(
    parameter  int NSOS = 4,
    parameter  int NCH  = 2,
    parameter  int WI   = 5,
    parameter  int WF   = 11,
    parameter  int WIC  = 5,
    parameter  int WFC  = 11,
    parameter  int GB   = 3,
    localparam int W    = WI + WF,
    localparam int WC   = WIC + WFC,
    localparam int WA   = W + WC + GB,
    localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int AW   = $clog2(6 * NSOS + 1)
) (
    input  logic                 CLK,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [CHW-1:0]       in_ch,
    input  logic signed [W-1:0]  din,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CHW-1:0]       out_ch,
    output logic signed [W-1:0]  dout,
    input  logic                 cfg_we,
    input  logic [AW-1:0]        cfg_addr,
    input  logic [WC-1:0]        cfg_data,
    output logic                 cfg_err,
    output logic                 ovf
);

    localparam int NST = NCH * NSOS;
    localparam int SIW = (NST > 1) ? $clog2(NST) : 1;
    localparam int SW  = (NSOS > 1) ? $clog2(NSOS) : 1;
    localparam int NCF = 6 * NSOS + 1;
    localparam int WP  = W + WC;

    localparam logic signed [WC-1:0] ONE_C    = WC'(32'd1 << WFC);
    localparam logic signed [WA-1:0] RND_HALF = WA'(64'd1 << (WFC - 1));
    localparam logic signed [WA-1:0] SAT_HI   = WA'((64'd1 << (W - 1)) - 64'd1);
    localparam logic signed [WA-1:0] SAT_LO   = ~SAT_HI;

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_CLEAR = 4'd1,
        S_SCALE = 4'd2,
        S_MAC0  = 4'd3,
        S_MAC1  = 4'd4,
        S_MAC2  = 4'd5,
        S_MAC3  = 4'd6,
        S_MAC4  = 4'd7,
        S_WB    = 4'd8,
        S_SOUT  = 4'd9,
        S_DONE  = 4'd10
    } state_t;

    // Round half-up at the coefficient fraction point, then clamp; MSB of the result flags a clamp.
    function automatic logic [W:0] rnd_sat(input logic signed [WA-1:0] a);
        logic signed [WA-1:0] r;
        r = (a + RND_HALF) >>> WFC;
        if (r > SAT_HI) begin
            rnd_sat = {1'b1, SAT_HI[W-1:0]};
        end else if (r < SAT_LO) begin
            rnd_sat = {1'b1, SAT_LO[W-1:0]};
        end else begin
            rnd_sat = {1'b0, r[W-1:0]};
        end
    endfunction

    state_t                state_r, state_s;
    logic [SW-1:0]         sec_r;
    logic [CHW-1:0]        ch_r;
    logic [SIW-1:0]        clr_cnt_r;
    logic signed [W-1:0]   v_r, x_r;
    logic signed [WA-1:0]  acc_r;
    logic signed [WC-1:0]  coef_r [NCF];
    logic signed [W-1:0]   x1_r [NST];
    logic signed [W-1:0]   x2_r [NST];
    logic signed [W-1:0]   y1_r [NST];
    logic signed [W-1:0]   y2_r [NST];
    logic                  out_valid_r, cfg_err_r, ovf_r;
    logic [CHW-1:0]        out_ch_r;
    logic signed [W-1:0]   dout_r;

    logic [SIW-1:0]        st_idx_s;
    logic [AW-1:0]         coef_base_s, cidx_s;
    logic signed [WC-1:0]  op_c_s;
    logic signed [W-1:0]   op_d_s;
    logic signed [WP-1:0]  prod_s;
    logic signed [WA-1:0]  rnd_in_s;
    logic [W:0]            sat_s;
    logic signed [W-1:0]   y_s;
    logic                  sat_flag_s, ch_valid_s, accept_s, cfg_ok_s, out_load_s, clr_last_s;

    assign st_idx_s    = SIW'(32'(ch_r) * 32'(NSOS) + 32'(sec_r));
    assign coef_base_s = AW'(32'(sec_r) * 32'd5);
    assign in_ready    = (state_r == S_IDLE) && !clear;
    assign accept_s    = in_valid && in_ready;
    assign cfg_ok_s    = cfg_we && (state_r == S_IDLE) && !out_valid_r && (cfg_addr < AW'(NCF));
    assign out_load_s  = (state_r == S_DONE) && (!out_valid_r || out_ready);
    assign clr_last_s  = (state_r == S_CLEAR) && (clr_cnt_r == SIW'(NST - 1));
    assign op_c_s      = coef_r[cidx_s];
    assign prod_s      = WP'(op_c_s) * WP'(op_d_s);
    assign rnd_in_s    = (state_r == S_WB) ? acc_r : WA'(prod_s);
    assign sat_s       = rnd_sat(rnd_in_s);
    assign y_s         = $signed(sat_s[W-1:0]);
    assign sat_flag_s  = sat_s[W];

    assign out_valid = out_valid_r;
    assign out_ch    = out_ch_r;
    assign dout      = dout_r;
    assign cfg_err   = cfg_err_r;
    assign ovf       = ovf_r;

    // Flag channel numbers beyond NCH so they fold onto channel 0.
    always_comb begin
        ch_valid_s = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (in_ch == CHW'(i)) begin
                ch_valid_s = 1'b1;
            end else begin
                ch_valid_s = ch_valid_s;
            end
        end
    end

    // Select the coefficient address and data operand feeding the shared multiplier.
    always_comb begin
        cidx_s = '0;
        op_d_s = '0;
        case (state_r)
            S_SCALE: begin cidx_s = AW'(32'(5 * NSOS) + 32'(sec_r)); op_d_s = v_r;            end
            S_MAC0:  begin cidx_s = coef_base_s;                      op_d_s = x_r;            end
            S_MAC1:  begin cidx_s = coef_base_s + AW'(32'd1);         op_d_s = x1_r[st_idx_s]; end
            S_MAC2:  begin cidx_s = coef_base_s + AW'(32'd2);         op_d_s = x2_r[st_idx_s]; end
            S_MAC3:  begin cidx_s = coef_base_s + AW'(32'd3);         op_d_s = y1_r[st_idx_s]; end
            S_MAC4:  begin cidx_s = coef_base_s + AW'(32'd4);         op_d_s = y2_r[st_idx_s]; end
            S_SOUT:  begin cidx_s = AW'(6 * NSOS);                    op_d_s = v_r;            end
            default: begin cidx_s = '0;                               op_d_s = '0;             end
        endcase
    end

    // FSM state register.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (clear) begin
                    state_s = S_CLEAR;
                end else if (in_valid) begin
                    state_s = S_SCALE;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_CLEAR: begin
                if (clr_last_s) begin
                    state_s = S_IDLE;
                end else begin
                    state_s = S_CLEAR;
                end
            end
            S_SCALE: state_s = S_MAC0;
            S_MAC0:  state_s = S_MAC1;
            S_MAC1:  state_s = S_MAC2;
            S_MAC2:  state_s = S_MAC3;
            S_MAC3:  state_s = S_MAC4;
            S_MAC4:  state_s = S_WB;
            S_WB: begin
                if (sec_r == SW'(NSOS - 1)) begin
                    state_s = S_SOUT;
                end else begin
                    state_s = S_SCALE;
                end
            end
            S_SOUT: state_s = S_DONE;
            S_DONE: begin
                if (out_load_s) begin
                    state_s = S_IDLE;
                end else begin
                    state_s = S_DONE;
                end
            end
            default: state_s = S_IDLE;
        endcase
    end

    // Coefficient file and write-reject pulse; reset restores a pass-through filter.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCF; i++) begin
                coef_r[i] <= ((i < 5 * NSOS) && (i % 5 != 0)) ? '0 : ONE_C;
            end
            cfg_err_r <= 1'b0;
        end else begin
            if (cfg_ok_s) begin
                coef_r[cfg_addr] <= cfg_data;
            end
            cfg_err_r <= cfg_we && !cfg_ok_s;
        end
    end

    // Sample working registers and the section accumulator.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            sec_r     <= '0;
            ch_r      <= '0;
            clr_cnt_r <= '0;
            v_r       <= '0;
            x_r       <= '0;
            acc_r     <= '0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    sec_r     <= '0;
                    clr_cnt_r <= '0;
                    if (accept_s) begin
                        v_r  <= din;
                        ch_r <= ch_valid_s ? in_ch : '0;
                    end
                end
                S_CLEAR: clr_cnt_r <= clr_cnt_r + 1'b1;
                S_SCALE: x_r <= y_s;
                S_MAC0:  acc_r <= WA'(prod_s);
                S_MAC1, S_MAC2: acc_r <= acc_r + WA'(prod_s);
                S_MAC3, S_MAC4: acc_r <= acc_r - WA'(prod_s);
                S_WB: begin
                    v_r   <= y_s;
                    sec_r <= sec_r + 1'b1;
                end
                S_SOUT:  v_r <= y_s;
                default: v_r <= v_r;
            endcase
        end
    end

    // Per-channel, per-section delay lines; the clear sweep zeroes one section slot per cycle.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NST; i++) begin
                x1_r[i] <= '0;
                x2_r[i] <= '0;
                y1_r[i] <= '0;
                y2_r[i] <= '0;
            end
        end else if (state_r == S_CLEAR) begin
            x1_r[clr_cnt_r] <= '0;
            x2_r[clr_cnt_r] <= '0;
            y1_r[clr_cnt_r] <= '0;
            y2_r[clr_cnt_r] <= '0;
        end else if (state_r == S_WB) begin
            x2_r[st_idx_s] <= x1_r[st_idx_s];
            x1_r[st_idx_s] <= x_r;
            y2_r[st_idx_s] <= y1_r[st_idx_s];
            y1_r[st_idx_s] <= y_s;
        end
    end

    // Output register with same-cycle consume-and-reload, plus the sticky overflow flag.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_ch_r    <= '0;
            dout_r      <= '0;
            ovf_r       <= 1'b0;
        end else begin
            if (out_load_s) begin
                out_valid_r <= 1'b1;
                out_ch_r    <= ch_r;
                dout_r      <= v_r;
            end else if (out_valid_r && out_ready) begin
                out_valid_r <= 1'b0;
            end
            if (clr_last_s) begin
                ovf_r <= 1'b0;
            end else if (sat_flag_s && ((state_r == S_SCALE) || (state_r == S_WB) || (state_r == S_SOUT))) begin
                ovf_r <= 1'b1;
            end else if (accept_s && !ch_valid_s) begin
                ovf_r <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_iir_sos_tdm_mc.sv
// Directed bench for iir_sos_tdm_mc: expected outputs are queued at input handshake
// and popped when the output handshake completes.
module tb_iir_sos_tdm_mc;

    localparam int W   = 16;
    localparam int CHW = 1;
    localparam int AW  = 5;

    logic           CLK = 1'b0;
    logic           rst;
    logic           clear;
    logic           in_valid;
    logic           in_ready;
    logic [CHW-1:0] in_ch;
    logic [W-1:0]   din;
    logic           out_valid;
    logic           out_ready;
    logic [CHW-1:0] out_ch;
    logic [W-1:0]   dout;
    logic           cfg_we;
    logic [AW-1:0]  cfg_addr;
    logic [W-1:0]   cfg_data;
    logic           cfg_err;
    logic           ovf;

    int n_checks = 0;
    int n_errors = 0;
    int lat;
    logic [W+CHW-1:0] exp_q [$];

    logic [W-1:0]   rec_exp [4] = '{16'h0400, 16'h0200, 16'h0100, 16'h0080};
    logic [CHW-1:0] iso_ch  [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [W-1:0]   iso_din [7] = '{16'h0800, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    logic [W-1:0]   iso_exp [7] = '{16'h0400, 16'h0000, 16'h0200, 16'h0000, 16'h0100, 16'h0000, 16'h0080};

    iir_sos_tdm_mc dut (
        .CLK       (CLK),
        .rst       (rst),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ch     (in_ch),
        .din       (din),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ch    (out_ch),
        .dout      (dout),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .cfg_err   (cfg_err),
        .ovf       (ovf)
    );

    always #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic send(input logic [CHW-1:0] c, input logic [W-1:0] d, input bit push, input logic [W-1:0] e);
        int n;
        n = 0;
        @(negedge CLK);
        in_valid = 1'b1;
        in_ch    = c;
        din      = d;
        while (!in_ready && n < 400) begin
            @(negedge CLK);
            n++;
        end
        chk("in_ready_wait", 32'(in_ready), 32'd1);
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
        if (push) exp_q.push_back({c, e});
    endtask

    task automatic wait_valid(output int cnt);
        cnt = 0;
        while (!out_valid && cnt < 400) begin
            @(posedge CLK);
            #1;
            cnt++;
        end
        chk("out_valid_wait", 32'(out_valid), 32'd1);
    endtask

    task automatic collect(input string tag, output int cnt);
        logic [W+CHW-1:0] e;
        wait_valid(cnt);
        if (exp_q.size() == 0) begin
            chk($sformatf("%s_unexpected", tag), 32'(out_valid), 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk($sformatf("%s_dout", tag), 32'(dout), 32'(e[W-1:0]));
            chk($sformatf("%s_ch", tag), 32'(out_ch), 32'(e[W+CHW-1:W]));
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic cfg(input logic [AW-1:0] a, input logic [W-1:0] d, input logic exp_err);
        @(negedge CLK);
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        @(posedge CLK);
        #1;
        cfg_we = 1'b0;
        chk($sformatf("cfg_err_a%0d", a), 32'(cfg_err), 32'(exp_err));
    endtask

    task automatic do_clear();
        int n;
        n = 0;
        @(negedge CLK);
        clear = 1'b1;
        @(posedge CLK);
        #1;
        clear = 1'b0;
        chk("clear_busy", 32'(in_ready), 32'd0);
        while (!in_ready && n < 100) begin
            @(negedge CLK);
            n++;
        end
        chk("clear_done", 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_ch = '0; din = '0;
        out_ready = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        repeat (3) @(posedge CLK);
        #1 rst = 1'b0;
        @(negedge CLK);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_out_ch", 32'(out_ch), 32'd0);
        chk("rst_cfg_err", 32'(cfg_err), 32'd0);

        // Pass-through with latency measurement
        send(1'b0, 16'h0800, 1'b1, 16'h0800);
        collect("pass", lat);
        chk("pass_latency", 32'(lat), 32'd30);
        chk("pass_ovf", 32'(ovf), 32'd0);

        // First-order recursion in section 0 on channel 1
        cfg(5'd0, 16'h0400, 1'b0);
        cfg(5'd3, 16'hFC00, 1'b0);
        for (int i = 0; i < 4; i++) begin
            send(1'b1, (i == 0) ? 16'h0800 : 16'h0000, 1'b1, rec_exp[i]);
            collect($sformatf("rec%0d", i), lat);
        end

        // Channel isolation from a cleared state
        do_clear();
        for (int i = 0; i < 7; i++) begin
            send(iso_ch[i], iso_din[i], 1'b1, iso_exp[i]);
            collect($sformatf("iso%0d", i), lat);
        end

        // Saturation then clear
        cfg(5'd0, 16'h4000, 1'b0);
        cfg(5'd3, 16'h0000, 1'b0);
        cfg(5'd5, 16'h4000, 1'b0);
        cfg(5'd25, 16'h1234, 1'b1);
        send(1'b0, 16'h0800, 1'b1, 16'h7FFF);
        collect("sat", lat);
        chk("sat_ovf", 32'(ovf), 32'd1);
        do_clear();
        chk("clear_ovf", 32'(ovf), 32'd0);

        // Backpressure: A held at the output, B parked in DONE, config writes rejected
        @(negedge CLK);
        out_ready = 1'b0;
        send(1'b0, 16'h0800, 1'b1, 16'h7FFF);
        wait_valid(lat);
        cfg(5'd0, 16'h0800, 1'b1);
        send(1'b1, 16'h0010, 1'b1, 16'h0400);
        cfg(5'd0, 16'h0800, 1'b1);
        repeat (40) @(negedge CLK);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        chk("bp_dout_stable", 32'(dout), 32'h7FFF);
        chk("bp_out_ch_stable", 32'(out_ch), 32'd0);
        out_ready = 1'b1;
        collect("bp_a", lat);
        chk("bp_no_bubble", 32'(out_valid), 32'd1);
        collect("bp_b", lat);
        send(1'b0, 16'h0800, 1'b1, 16'h7FFF);
        collect("coef_kept", lat);

        // Config write and sample in the same cycle
        cfg(5'd5, 16'h0800, 1'b0);
        @(negedge CLK);
        chk("same_cyc_ready", 32'(in_ready), 32'd1);
        cfg_we = 1'b1; cfg_addr = 5'd0; cfg_data = 16'h0800;
        in_valid = 1'b1; in_ch = 1'b0; din = 16'h0800;
        @(posedge CLK);
        #1;
        cfg_we = 1'b0; in_valid = 1'b0;
        exp_q.push_back({1'b0, 16'h0800});
        chk("same_cyc_cfg_err", 32'(cfg_err), 32'd0);
        collect("same_cyc", lat);

        // Reset in the middle of a sample restores defaults
        cfg(5'd0, 16'h0400, 1'b0);
        send(1'b0, 16'h0800, 1'b0, 16'h0000);
        repeat (11) @(posedge CLK);
        #1 rst = 1'b1;
        @(negedge CLK);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        @(posedge CLK);
        #1 rst = 1'b0;
        @(negedge CLK);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_out_valid_after", 32'(out_valid), 32'd0);
        send(1'b0, 16'h0800, 1'b1, 16'h0800);
        collect("midrst", lat);
        chk("midrst_latency", 32'(lat), 32'd30);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
